cache_data_array_n: RTL and testbench

Parametrised, multi-way line data array for the L1 caches. It replaces the single-way 8-set combinational-read array. The block adds the following over that array:
- N ways
- configurable set count and line width
- per-byte write masks
- registered (1-cycle) reads with write-first bypass
- a multi-cycle reset sweep with a ready flag, replacing the single-cycle clear of all entries

Cache controllers read all ways of a set in parallel for tag-hit selection and write one way per cycle.

---
 rtl/cache_data_pkg.sv | 32 +++
 rtl/cache_data_array_n_way.sv | 30 +++
 rtl/cache_data_array_n.sv | 110 +++++++++++
 tb/tb_cache_data_array_n.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_data_pkg.sv
// Shared types and helpers for the multi-way cache line data array.
// Widths up to MAX_LINE_BITS are handled by zero-extending at the call site.
package cache_data_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int MAX_LINE_BITS = 1024;
  localparam int MAX_MASK_BITS = MAX_LINE_BITS / 8;

  // Byte i of the result comes from new_line when mask[i] is set, else from old_line.
  function automatic logic [MAX_LINE_BITS-1:0] merge_bytes(
    input logic [MAX_LINE_BITS-1:0] old_line,
    input logic [MAX_LINE_BITS-1:0] new_line,
    input logic [MAX_MASK_BITS-1:0] mask
  );
    logic [MAX_LINE_BITS-1:0] result;
    result = old_line;
    for (int b = 0; b < MAX_MASK_BITS; b++) begin
      if (mask[b]) result[b*8 +: 8] = new_line[b*8 +: 8];
    end
    return result;
  endfunction

  // Low bit position of a lane in a packed vector of equal-width lanes.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/cache_data_array_n_way.sv
// Storage for one way: byte-masked synchronous write, combinational read.
module cache_data_way #(
  parameter int S_INDEX   = 3,
  parameter int LINE_BITS = 256
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [S_INDEX-1:0]     index,
  input  logic [LINE_BITS/8-1:0] mask,
  input  logic [LINE_BITS-1:0]   data,
  input  logic [S_INDEX-1:0]     rd_index,
  output logic [LINE_BITS-1:0]   rd_line
);

  localparam int SETS      = 2 ** S_INDEX;
  localparam int MASK_BITS = LINE_BITS / 8;

  logic [LINE_BITS-1:0] mem [SETS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < MASK_BITS; b++) begin
        if (mask[b]) mem[index][b*8 +: 8] <= data[b*8 +: 8];
      end
    end
  end

  assign rd_line = mem[rd_index];

endmodule

// File: rtl/cache_data_array_n.sv
// N-way cache line data array with a reset-time clear sweep, byte-masked
// writes and a registered all-ways read with write-first bypass.
module cache_data_array_n
  import cache_data_pkg::*;
#(
  parameter int S_INDEX   = 3,
  parameter int NUM_WAYS  = 4,
  parameter int LINE_BITS = 256,
  localparam int MASK_BITS = LINE_BITS / 8,
  localparam int WAY_BITS  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          ready,
  input  logic                          rd_en,
  input  logic [S_INDEX-1:0]            rd_index,
  output logic [NUM_WAYS*LINE_BITS-1:0] rd_data,
  input  logic                          wr_en,
  input  logic [WAY_BITS-1:0]           wr_way,
  input  logic [S_INDEX-1:0]            wr_index,
  input  logic [MASK_BITS-1:0]          wr_mask,
  input  logic [LINE_BITS-1:0]          wr_data
);

  state_t                          state_reg, state_next;
  logic [S_INDEX-1:0]              clr_cnt_reg, clr_cnt_next;
  logic [NUM_WAYS*LINE_BITS-1:0]   rd_data_reg, rd_data_next;

  logic clearing;
  logic running;
  logic same_set;

  assign clearing = (state_reg == CLEAR);
  assign running  = (state_reg == RUN);
  assign same_set = (wr_index == rd_index);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
      rd_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
      if (running && rd_en) rd_data_reg <= rd_data_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    case (state_reg)
      CLEAR: begin
        clr_cnt_next = clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == {S_INDEX{1'b1}}) state_next = RUN;
      end
      RUN:     state_next = RUN;
      default: state_next = CLEAR;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
      localparam int LO = lane_lo(gi, LINE_BITS);

      logic                 way_sel;
      logic                 way_we;
      logic [S_INDEX-1:0]   way_index;
      logic [MASK_BITS-1:0] way_mask;
      logic [LINE_BITS-1:0] way_data;
      logic [LINE_BITS-1:0] stored;

      // An out-of-range wr_way matches no lane, so the write is dropped.
      assign way_sel   = wr_en && (wr_way == WAY_BITS'(gi));
      assign way_we    = !rst && (clearing || (running && way_sel));
      assign way_index = clearing ? clr_cnt_reg : wr_index;
      assign way_mask  = clearing ? {MASK_BITS{1'b1}} : wr_mask;
      assign way_data  = clearing ? '0 : wr_data;

      cache_data_way #(
        .S_INDEX  (S_INDEX),
        .LINE_BITS(LINE_BITS)
      ) u_way (
        .clk     (clk),
        .we      (way_we),
        .index   (way_index),
        .mask    (way_mask),
        .data    (way_data),
        .rd_index(rd_index),
        .rd_line (stored)
      );

      // Write-first: a same-cycle write to the read set is visible in the result.
      always_comb begin
        rd_data_next[LO +: LINE_BITS] = stored;
        if (way_sel && same_set) begin
          rd_data_next[LO +: LINE_BITS] = LINE_BITS'(merge_bytes(
            MAX_LINE_BITS'(stored),
            MAX_LINE_BITS'(wr_data),
            MAX_MASK_BITS'(wr_mask)));
        end
      end
    end
  endgenerate

  assign rd_data = rd_data_reg;
  assign ready   = running;

endmodule

// File: tb/tb_cache_data_array_n.sv
// Randomised and directed checks of cache_data_array_n against a line-level model.
module tb_cache_data_array_n;

  localparam int SI   = 3;
  localparam int SETS = 8;
  localparam int NW   = 3;
  localparam int LB   = 256;
  localparam int MB   = LB / 8;
  localparam int WB   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              ready;
  logic              rd_en;
  logic [SI-1:0]     rd_index;
  logic [NW*LB-1:0]  rd_data;
  logic              wr_en;
  logic [WB-1:0]     wr_way;
  logic [SI-1:0]     wr_index;
  logic [MB-1:0]     wr_mask;
  logic [LB-1:0]     wr_data;

  cache_data_array_n #(.S_INDEX(SI), .NUM_WAYS(NW), .LINE_BITS(LB)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .rd_en(rd_en), .rd_index(rd_index), .rd_data(rd_data),
    .wr_en(wr_en), .wr_way(wr_way), .wr_index(wr_index),
    .wr_mask(wr_mask), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: line contents per (set, way), remaining sweep cycles, expected outputs.
  logic [LB-1:0]    mm [SETS][NW];
  int               sweep_left = SETS;
  logic [NW*LB-1:0] exp_rd, nxt_rd;
  logic             exp_ready, nxt_ready;
  bit               model_valid = 0;

  task automatic model_step();
    nxt_rd    = exp_rd;
    nxt_ready = exp_ready;
    if (rst) begin
      sweep_left = SETS;
      nxt_rd     = '0;
      nxt_ready  = 1'b0;
    end else if (sweep_left > 0) begin
      for (int w = 0; w < NW; w++) mm[SETS - sweep_left][w] = '0;
      sweep_left--;
      if (sweep_left == 0) nxt_ready = 1'b1;
    end else begin
      if (wr_en && int'(wr_way) < NW) begin
        for (int b = 0; b < MB; b++)
          if (wr_mask[b]) mm[wr_index][wr_way][b*8 +: 8] = wr_data[b*8 +: 8];
      end
      if (rd_en) begin
        for (int w = 0; w < NW; w++) nxt_rd[w*LB +: LB] = mm[rd_index][w];
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    exp_rd      = nxt_rd;
    exp_ready   = nxt_ready;
    model_valid = 1;
    #1;
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (ready !== exp_ready) begin
        failures++;
        $display("FAIL ready t=%0t got=%b want=%b", $time, ready, exp_ready);
      end
      checks++;
      if (rd_data !== exp_rd) begin
        failures++;
        $display("FAIL rd_data t=%0t got=%h want=%h", $time, rd_data, exp_rd);
      end
    end
  end

  task automatic check(input string name, input logic [NW*LB-1:0] act, input logic [NW*LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end else begin
      $display("ok   %s", name);
    end
  endtask

  task automatic sweep_wait(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!ready && n < 20);
  endtask

  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] l;
    for (int i = 0; i < LB / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic idle();
    rd_en = 0; wr_en = 0;
  endtask

  initial begin
    int n;
    logic [LB-1:0]    l3, l5;
    logic [NW*LB-1:0] e3, e5;

    rst = 1; rd_en = 0; wr_en = 0; rd_index = '0; wr_index = '0;
    wr_way = '0; wr_mask = '0; wr_data = '0;

    // Reset sweep length and all-zero contents
    cyc(); cyc();
    rst = 0;
    sweep_wait(n);
    check("sweep_len", NW*LB'(n), NW*LB'(8));
    for (int s = 0; s < SETS; s++) begin
      rd_en = 1; rd_index = SI'(s);
      cyc();
      check($sformatf("zero_set%0d", s), rd_data, '0);
    end
    idle();

    // Reset reasserted at clr_cnt=5
    rst = 1; cyc();
    rst = 0; repeat (5) cyc();
    rst = 1; cyc();
    rst = 0;
    sweep_wait(n);
    check("mid_sweep_len", NW*LB'(n), NW*LB'(8));

    // Masked write onto a full line
    wr_en = 1; wr_way = 2; wr_index = 4; wr_mask = '1; wr_data = {MB{8'hAA}};
    cyc();
    wr_data = {MB{8'h55}}; wr_mask = 32'h0000_000F;
    cyc();
    wr_en = 0; rd_en = 1; rd_index = 4;
    cyc();
    l3 = {{28{8'hAA}}, {4{8'h55}}};
    e3 = {l3, {LB{1'b0}}, {LB{1'b0}}};
    check("masked_write", rd_data, e3);

    // Write-first bypass on a partially filled set
    rd_en = 0; wr_en = 1; wr_index = 6; wr_mask = '1;
    wr_way = 1; wr_data = {MB{8'hCC}}; cyc();
    wr_way = 0; wr_data = {MB{8'h77}}; cyc();
    wr_way = 1; wr_mask = 32'h1; wr_data = {{31{8'h00}}, 8'h11};
    rd_en = 1; rd_index = 6;
    cyc();
    check("bypass", rd_data, {{LB{1'b0}}, {{31{8'hCC}}, 8'h11}, {MB{8'h77}}});

    // Read hold while the read set is being written
    wr_en = 0; rd_index = 4; cyc();
    rd_en = 0; wr_en = 1; wr_way = 0; wr_index = 4; wr_mask = '1;
    for (int k = 0; k < 3; k++) begin
      wr_data = {MB{8'h90 + 8'(k)}};
      cyc();
      check($sformatf("hold%0d", k), rd_data, e3);
    end
    wr_en = 0; rd_en = 1;
    cyc();
    l5 = {MB{8'h92}};
    e5 = {l3, {LB{1'b0}}, l5};
    check("read_after_hold", rd_data, e5);

    // Out-of-range way is dropped
    rd_en = 0; wr_en = 1; wr_way = 3; wr_index = 4; wr_mask = '1; wr_data = '1;
    cyc();
    wr_en = 0; rd_en = 1; cyc();
    check("illegal_way", rd_data, e5);

    // Requests during the sweep are dropped and rd_data stays zero
    rst = 1; cyc();
    rst = 0; wr_en = 1; wr_way = 0; wr_index = 0; wr_mask = '1; wr_data = '1;
    rd_en = 1; rd_index = 0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      check($sformatf("clear_rd%0d", k), rd_data, '0);
    end
    cyc();
    wr_en = 0; rd_index = 0;
    cyc();
    check("clear_wr_dropped", rd_data, '0);

    // Random traffic, occasional reset
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      rd_en    = $urandom_range(0, 1);
      wr_en    = $urandom_range(0, 1);
      rd_index = SI'($urandom);
      wr_index = ($urandom_range(0, 2) == 0) ? rd_index : SI'($urandom);
      wr_way   = WB'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       wr_mask = '1;
        1:       wr_mask = '0;
        default: wr_mask = $urandom;
      endcase
      wr_data = rand_line();
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
